button_event: RTL and testbench
===============================

Name: button_event

Overview:
- Sits directly downstream of the vending-machine button debouncer.
- Takes the clean, synchronous debounced level and turns it into single-cycle event pulses: press, release, long-press and auto-repeat.
- The vending FSM consumes only these pulses, never raw levels.

Parameters:
- CLK_FREQ, 25_000_000, clock frequency in Hz.
- LONG_MS, 1000, hold time in ms before long_o fires.
- REPEAT_MS, 200, auto-repeat period in ms after long_o.

Ports:
- clk_i  input  1  system clock.
- rst_ni  input  1  reset; synchronous, active-low.
- level_i  input  1  debounced button level, already synchronous to clk_i; 1 = pressed.
- repeat_en_i  input  1  enables auto-repeat pulses in HELD.
- held_o  output  1  level; high while state is PRESSED or HELD.
- press_o  output  1  one-cycle pulse on press.
- release_o  output  1  one-cycle pulse on release.
- long_o  output  1  one-cycle pulse when hold reaches LONG time.
- repeat_o  output  1  one-cycle pulse every REPEAT period while held past LONG.

Behaviour:
- Derived constants:
  - LONG_CYC = CLK_FREQ*LONG_MS/1000.
  - REP_CYC = CLK_FREQ*REPEAT_MS/1000.
  - Both must be >= 2; elaboration error otherwise.
  - Counter width = $clog2(max(LONG_CYC, REP_CYC)+1), unsigned.
- Outputs: all registered, all reset to 0.
- Reset (rst_ni=0 at a clk edge):
  - state=IDLE, level_q=0, cnt=0, all outputs 0.
  - Applies mid-press too: no release_o is generated for a press aborted by reset.
  - If level_i=1 at the first edge after reset release, a press is detected (level_q resets to 0).
- Edge detect: level_q <= level_i every cycle.
  - rise = level_i & ~level_q.
  - fall = ~level_i & level_q.
- FSM states: IDLE, PRESSED, HELD.
  - IDLE:
    - On rise: press_o=1 next cycle, held_o=1 from the next cycle, cnt<=1, go to PRESSED.
    - Otherwise: cnt=0.
  - PRESSED:
    - On fall: release_o=1 next cycle, go to IDLE, cnt<=0.
    - Else if cnt==LONG_CYC: long_o=1 next cycle, cnt<=1, go to HELD.
    - Else: cnt<=cnt+1.
    - Net timing: long_o is high exactly LONG_CYC cycles after press_o.
  - HELD:
    - On fall: release_o=1 next cycle, go to IDLE, cnt<=0.
    - Else if cnt==REP_CYC: repeat_o=repeat_en_i next cycle, cnt<=1.
    - Else: cnt<=cnt+1.
    - Net timing: repeat pulses occur every REP_CYC cycles, the first REP_CYC cycles after long_o.
- repeat_en_i:
  - Sampled only at the terminal-count cycle.
  - Deasserting it suppresses pulses but does not stop the counter or change state.
- Simultaneous events: fall in the same cycle as a terminal count means release wins; no long_o or repeat_o is issued.
- Exclusivity: press_o, release_o, long_o and repeat_o are mutually exclusive in any cycle.
- held_o:
  - Goes high in the same cycle as press_o.
  - Goes low in the same cycle as release_o.
- No other state change occurs without a level_i edge.
- Minimum activity: press and release are separated by at least 1 cycle, since the debouncer guarantees this.

Test Plan:
- Sim params for all scenarios: CLK_FREQ=1000, LONG_MS=10, REPEAT_MS=3, giving LONG_CYC=10 and REP_CYC=3.
- Short press: level_i high for 4 cycles then low -> press_o at cycle t+1, release_o 4 cycles later; long_o never fires; held_o high exactly 4 cycles.
- Long hold, repeat_en_i=1: hold 20 cycles -> press_o at t+1, long_o at t+11, repeat_o at t+14, t+17, t+20; release_o after fall; held_o high throughout.
- Repeat disabled: same as the long-hold case with repeat_en_i=0 -> long_o at t+11, zero repeat_o pulses, release_o still correct.
- Race: level_i falls exactly at the edge where cnt==10 -> release_o=1, long_o stays 0, state IDLE.
- Reset mid-hold: assert rst_ni=0 at t+6 of a hold -> all outputs 0 next cycle, no release_o; deassert with level_i=1 -> fresh press_o one cycle after the first active edge.
- Back-to-back: press/release/press with 1-cycle gaps -> press_o, release_o, press_o each single-cycle; counter restarts (long_o 10 cycles after the second press_o).

Source files
------------

// File: rtl/button_event.sv
// Turns a clean debounced button level into single-cycle press / release /
// long-press / auto-repeat pulses plus a registered "held" level.
module button_event #(
    parameter int CLK_FREQ  = 25_000_000,
    parameter int LONG_MS   = 1000,
    parameter int REPEAT_MS = 200
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic level_i,
    input  logic repeat_en_i,
    output logic held_o,
    output logic press_o,
    output logic release_o,
    output logic long_o,
    output logic repeat_o
);

    // 64-bit math so the default 25 MHz * 1000 ms product cannot overflow.
    localparam longint LONG_CYC = longint'(CLK_FREQ) * longint'(LONG_MS) / 1000;
    localparam longint REP_CYC  = longint'(CLK_FREQ) * longint'(REPEAT_MS) / 1000;
    localparam longint MAX_CYC  = (LONG_CYC > REP_CYC) ? LONG_CYC : REP_CYC;
    localparam int     CW       = $clog2(MAX_CYC + 1);

    localparam logic [CW-1:0] LONG_TC = CW'(LONG_CYC);
    localparam logic [CW-1:0] REP_TC  = CW'(REP_CYC);
    localparam logic [CW-1:0] ONE     = CW'(1);

    if (LONG_CYC < 2 || REP_CYC < 2) begin : g_bad_cfg
        $error("button_event: LONG_CYC and REP_CYC must both be >= 2");
    end

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PRESSED = 2'd1,
        HELD    = 2'd2
    } state_t;

    state_t        state, state_d;
    logic [CW-1:0] cnt, cnt_d;
    logic          level_q;
    logic          rise, fall;
    logic          held_d, press_d, release_d, long_d, repeat_d;

    assign rise = level_i & ~level_q;
    assign fall = ~level_i & level_q;

    // State, counter, edge history and all outputs are registered together.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state     <= IDLE;
            cnt       <= '0;
            level_q   <= 1'b0;
            held_o    <= 1'b0;
            press_o   <= 1'b0;
            release_o <= 1'b0;
            long_o    <= 1'b0;
            repeat_o  <= 1'b0;
        end else begin
            state     <= state_d;
            cnt       <= cnt_d;
            level_q   <= level_i;
            held_o    <= held_d;
            press_o   <= press_d;
            release_o <= release_d;
            long_o    <= long_d;
            repeat_o  <= repeat_d;
        end
    end

    // A fall always takes priority over a terminal count in the same cycle.
    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        unique case (state)
            IDLE: begin
                if (rise) begin
                    state_d = PRESSED;
                    cnt_d   = ONE;
                end else begin
                    cnt_d   = '0;
                end
            end
            PRESSED: begin
                if (fall) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt == LONG_TC) begin
                    state_d = HELD;
                    cnt_d   = ONE;
                end else begin
                    cnt_d   = cnt + ONE;
                end
            end
            HELD: begin
                if (fall) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt == REP_TC) begin
                    cnt_d   = ONE;
                end else begin
                    cnt_d   = cnt + ONE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // repeat_en_i only gates the pulse; the repeat counter keeps running.
    always_comb begin
        held_d    = (state_d != IDLE);
        press_d   = (state == IDLE) & rise;
        release_d = ((state == PRESSED) | (state == HELD)) & fall;
        long_d    = (state == PRESSED) & ~fall & (cnt == LONG_TC);
        repeat_d  = (state == HELD) & ~fall & (cnt == REP_TC) & repeat_en_i;
    end

endmodule

// File: tb/tb_button_event.sv
// Bench for button_event: fixed vector table, hand-written hold / reset
// sequences, and random level traffic against an event-level model.
module tb_button_event;

    localparam int LONG = 10;
    localparam int REP  = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0, lvl = 1'b0, en = 1'b0;
    logic held, press, rel, lng, rep;

    int total = 0;
    int bad = 0;

    // model state: last level seen, pressed flag, edges since the press edge
    bit m_lq = 0, m_pressed = 0;
    int m_hold = 0;

    typedef struct {
        bit         r;
        bit         l;
        bit         e;
        logic [4:0] exp;  // {held, press, release, long, repeat}
    } vec_t;

    vec_t vq[$];

    always #5 clk = ~clk;

    button_event #(.CLK_FREQ(1000), .LONG_MS(10), .REPEAT_MS(3)) dut (
        .clk_i(clk), .rst_ni(rst_n), .level_i(lvl), .repeat_en_i(en),
        .held_o(held), .press_o(press), .release_o(rel),
        .long_o(lng), .repeat_o(rep)
    );

    task automatic check(string name, int act, int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // Expected outputs from the event rules: long after LONG edges of holding,
    // then a repeat every REP edges; a fall ends the press before anything else.
    function automatic logic [4:0] model(bit r, bit l, bit e);
        bit p = 0, rl = 0, lg = 0, rp = 0;
        if (!r) begin
            m_lq = 0; m_pressed = 0; m_hold = 0;
            return 5'b0;
        end
        if (!m_pressed) begin
            if (l && !m_lq) begin
                m_pressed = 1; m_hold = 0; p = 1;
            end
        end else if (!l && m_lq) begin
            m_pressed = 0; rl = 1;
        end else begin
            m_hold++;
            if (m_hold == LONG) lg = 1;
            else if (m_hold > LONG && (m_hold - LONG) % REP == 0) rp = e;
        end
        m_lq = l;
        return {m_pressed, p, rl, lg, rp};
    endfunction

    task automatic step(bit r, bit l, bit e, output logic [4:0] got);
        logic [4:0] m;
        rst_n = r; lvl = l; en = e;
        @(posedge clk); #1;
        m = model(r, l, e);
        got = {held, press, rel, lng, rep};
        check("model", int'(got), int'(m));
    endtask

    task automatic add(bit r, bit l, bit e, logic [4:0] exp, int n = 1);
        vec_t v;
        v.r = r; v.l = l; v.e = e; v.exp = exp;
        for (int i = 0; i < n; i++) vq.push_back(v);
    endtask

    // Hold level for n edges then release; record where each pulse lands.
    task automatic hold_run(int n, bit e, string tag);
        logic [4:0] g;
        int long_at = -1, rel_at = -1, rep_n = 0, first_rep = -1, held_n = 0, press_n = 0;
        for (int i = 0; i <= n; i++) begin
            step(1, i < n, e, g);
            if (g[4]) held_n++;
            if (g[3]) press_n++;
            if (g[1]) long_at = i;
            if (g[0]) begin
                rep_n++;
                if (first_rep < 0) first_rep = i;
            end
            if (g[2]) rel_at = i;
        end
        check({tag, "_press_n"}, press_n, 1);
        check({tag, "_long_at"}, long_at, LONG);
        check({tag, "_rep_n"}, rep_n, e ? 3 : 0);
        check({tag, "_first_rep"}, first_rep, e ? LONG + REP : -1);
        check({tag, "_rel_at"}, rel_at, n);
        check({tag, "_held_n"}, held_n, n);
    endtask

    initial begin
        logic [4:0] g;
        bit rl = 0, re = 1, rr;
        int run = 0;

        // reset, short press (4 cycles), race at terminal count, back-to-back
        add(0, 0, 1, 5'b00000, 2);
        add(1, 0, 1, 5'b00000);
        add(1, 1, 1, 5'b11000);
        add(1, 1, 1, 5'b10000, 3);
        add(1, 0, 1, 5'b00100);
        add(1, 0, 1, 5'b00000);
        add(1, 1, 1, 5'b11000);
        add(1, 1, 1, 5'b10000, 9);
        add(1, 0, 1, 5'b00100);
        add(1, 0, 1, 5'b00000, 2);
        add(1, 1, 1, 5'b11000);
        add(1, 0, 1, 5'b00100);
        add(1, 1, 1, 5'b11000);
        add(1, 1, 1, 5'b10000, 9);
        add(1, 1, 1, 5'b10010);
        add(1, 0, 1, 5'b00100);
        add(1, 0, 1, 5'b00000);

        foreach (vq[i]) begin
            step(vq[i].r, vq[i].l, vq[i].e, g);
            check($sformatf("vec%0d", i), int'(g), int'(vq[i].exp));
        end

        hold_run(20, 1'b1, "long_rep");
        step(1, 0, 1, g);
        hold_run(20, 1'b0, "long_norep");
        step(1, 0, 0, g);

        // reset in the middle of a hold, level still high on release
        step(1, 1, 1, g);
        check("mid_press", int'(g), 5'b11000);
        for (int i = 0; i < 5; i++) step(1, 1, 1, g);
        step(0, 1, 1, g);
        check("mid_reset", int'(g), 5'b00000);
        step(1, 1, 1, g);
        check("repress", int'(g), 5'b11000);
        step(1, 0, 1, g);
        check("repress_rel", int'(g), 5'b00100);

        // random level runs, repeat enable toggles and occasional resets
        for (int c = 0; c < 3000; c++) begin
            if (run == 0) begin
                rl = ~rl;
                run = ($urandom_range(0, 3) == 0) ? $urandom_range(10, 30)
                                                  : $urandom_range(1, 12);
            end
            run--;
            if ($urandom_range(0, 7) == 0) re = ~re;
            rr = ($urandom_range(0, 99) != 0);
            step(rr, rl, re, g);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
